// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - frame buffer geometry constants and write scheduler state type
package fb_pkg;
  localparam int FB_H      = 320;
  localparam int FB_V      = 240;
  localparam int FB_PIXELS = FB_H * FB_V;
  localparam int FB_ADDR_W = 17;
  localparam int FB_PIX_W  = 8;

  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

  typedef enum logic [1:0] {
    CLR_ALL = 2'd0,
    STREAM  = 2'd1,
    CLR_ONE = 2'd2
  } fb_sched_state_t;
endpackage

// File: rtl/fb_clear_engine.sv
// rtl/fb_clear_engine.sv - clear address generator; walks one bank, or both banks when i_two_banks is set
module fb_clear_engine
  import fb_pkg::*;
#(
  parameter int NUM_PIXELS = FB_PIXELS,
  parameter int ADDR_W     = FB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_active,
  input  logic              i_two_banks,
  input  logic              i_stall,
  input  logic              i_start,
  input  logic              i_start_bank,
  output logic [ADDR_W-1:0] o_cnt,
  output logic              o_bank,
  output logic              o_go,
  output logic              o_done
);
  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(NUM_PIXELS - 1);

  logic [ADDR_W-1:0] r_cnt;
  logic              r_bank;
  logic              w_at_last;
  logic              w_more;

  assign w_at_last = (r_cnt == LP_LAST);
  // A full clear continues into bank 1 after finishing bank 0
  assign w_more    = i_two_banks & ~r_bank;
  assign o_go      = i_active & ~i_stall;
  assign o_done    = o_go & w_at_last & ~w_more;
  assign o_cnt     = r_cnt;
  assign o_bank    = r_bank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_bank <= 1'b0;
    end else if (i_start) begin
      r_cnt  <= '0;
      r_bank <= i_start_bank;
    end else if (o_go) begin
      if (w_at_last) begin
        r_cnt <= '0;
        if (w_more) r_bank <= 1'b1;
      end else begin
        r_cnt <= r_cnt + ADDR_W'(1);
      end
    end
  end
endmodule

// File: rtl/fb_write_scheduler.sv
// rtl/fb_write_scheduler.sv - ping-pong frame buffer write arbiter and bank swapper; FB_SCHED_STATS_EN adds frame/drop counters
module fb_write_scheduler
  import fb_pkg::*;
#(
  parameter int               NUM_PIXELS  = FB_PIXELS,
  parameter int               ADDR_W      = FB_ADDR_W,
  parameter int               PIX_W       = FB_PIX_W,
  parameter logic [PIX_W-1:0] CLEAR_VALUE = PIX_W'(8'h00)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_axiiv,
  input  logic [ADDR_W-1:0] pix_addr_axiid,
  input  logic [PIX_W-1:0]  pix_axiid,
  input  logic              clear_req,
  output logic              fb_we,
  output logic [ADDR_W:0]   fb_addr,
  output logic [PIX_W-1:0]  fb_din,
  output logic              disp_bank,
  output logic              frame_done,
  output logic              clear_busy
`ifdef FB_SCHED_STATS_EN
  ,
  output logic [15:0]       frame_count,
  output logic [15:0]       drop_count
`endif
);
  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(NUM_PIXELS - 1);

  fb_sched_state_t   r_state, w_state_nxt;
  logic              r_wr_bank;
  logic              w_in_range, w_pix_ok, w_drop, w_swap;
  logic              w_clr_active, w_start, w_wr_bank_nxt;
  logic [ADDR_W-1:0] w_clr_cnt;
  logic              w_clr_bank, w_clr_go, w_clr_done;

  assign w_in_range    = (pix_addr_axiid <= LP_LAST);
  assign w_pix_ok      = pix_axiiv & w_in_range;
  assign w_drop        = pix_axiiv & ~w_in_range;
  assign w_swap        = w_pix_ok & (pix_addr_axiid == LP_LAST);
  assign w_clr_active  = (r_state != STREAM);
  assign w_start       = clear_req & (r_state == STREAM);
  // A clear requested alongside a swap must target the bank being written next
  assign w_wr_bank_nxt = r_wr_bank ^ w_swap;

  fb_clear_engine #(
    .NUM_PIXELS (NUM_PIXELS),
    .ADDR_W     (ADDR_W)
  ) u_clear (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_active     (w_clr_active),
    .i_two_banks  (r_state == CLR_ALL),
    .i_stall      (w_pix_ok),
    .i_start      (w_start),
    .i_start_bank (w_wr_bank_nxt),
    .o_cnt        (w_clr_cnt),
    .o_bank       (w_clr_bank),
    .o_go         (w_clr_go),
    .o_done       (w_clr_done)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CLR_ALL, CLR_ONE: if (w_clr_done) w_state_nxt = STREAM;
      STREAM:           if (w_start)    w_state_nxt = CLR_ONE;
      default:          w_state_nxt = CLR_ALL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= CLR_ALL;
      r_wr_bank  <= 1'b0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_din     <= '0;
      disp_bank  <= 1'b1;
      frame_done <= 1'b0;
      clear_busy <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_bank  <= w_wr_bank_nxt;
      fb_we      <= w_pix_ok | w_clr_go;
      if (w_pix_ok) begin
        fb_addr <= {r_wr_bank, pix_addr_axiid};
        fb_din  <= pix_axiid;
      end else if (w_clr_go) begin
        fb_addr <= {w_clr_bank, w_clr_cnt};
        fb_din  <= CLEAR_VALUE;
      end
      if (w_swap) disp_bank <= r_wr_bank;
      frame_done <= w_swap;
      // Lags the state by one cycle so it stays high through the last visible clear write
      clear_busy <= w_clr_active;
    end
  end

`ifdef FB_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      if (w_swap) frame_count <= frame_count + 16'd1;
      if (w_drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end
`endif
endmodule
